// File: rtl/lif_spike_window.sv
// lif_spike_window: counts LIF neuron spikes over a programmable window of
// timesteps and queues each completed window count in a small FIFO that the
// readout logic drains through a valid/ready port.
//
// Optional feature macro: LIF_SPIKE_WINDOW_INDEX_EN
//   Adds an 8-bit window index stored alongside each count and presented on
//   out_index, so the consumer can detect windows lost to a full FIFO.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | not windowing; step_valid/spike_in ignored; FIFO still drains
// RUN   | counting spikes per step; window end pushes count into FIFO
module lif_spike_window #(
  parameter int COUNT_BITS  = 8,
  parameter int WINDOW_BITS = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [WINDOW_BITS-1:0] window_len,
  input  logic                   step_valid,
  input  logic                   spike_in,
  output logic [COUNT_BITS-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   dropped,
  output logic                   busy
`ifdef LIF_SPIKE_WINDOW_INDEX_EN
  ,
  output logic [7:0]             out_index
`endif
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;
`ifdef LIF_SPIKE_WINDOW_INDEX_EN
  localparam int ENTRY_W = COUNT_BITS + 8;
`else
  localparam int ENTRY_W = COUNT_BITS;
`endif

  localparam logic [WINDOW_BITS-1:0] LEN_ONE = WINDOW_BITS'(1);
  localparam logic [PTR_W-1:0]       PTR_ONE = PTR_W'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                 state, state_next;
  logic [WINDOW_BITS-1:0] len;
  logic [WINDOW_BITS-1:0] step_cnt;
  logic [COUNT_BITS-1:0]  spike_cnt;
  logic [COUNT_BITS-1:0]  spike_cnt_next;
  logic                   restart;
  logic                   run_step;
  logic                   win_end;

  logic [ENTRY_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic                   fifo_empty, fifo_full;
  logic                   pop, push_ok, push_drop;
  logic [ENTRY_W-1:0]     push_word;
  logic [ENTRY_W-1:0]     head_word;

`ifdef LIF_SPIKE_WINDOW_INDEX_EN
  logic [7:0]             win_idx;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and per-cycle control decode; stop wins over start, and a
  // start pulse takes precedence over a step arriving in the same cycle.
  always_comb begin
    state_next     = state;
    restart        = start && !stop;
    run_step       = 1'b0;
    win_end        = 1'b0;
    spike_cnt_next = spike_cnt;
    busy           = (state == RUN);
    case (state)
      IDLE: if (restart) state_next = RUN;
      RUN: begin
        if (stop) state_next = IDLE;
        run_step = step_valid && !start && !stop;
        if (spike_in && (spike_cnt != {COUNT_BITS{1'b1}}))
          spike_cnt_next = spike_cnt + COUNT_BITS'(1);
        win_end = run_step && (step_cnt == len - LEN_ONE);
      end
      default: state_next = IDLE;
    endcase
  end

  // Window length latch and step/spike counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len       <= LEN_ONE;
      step_cnt  <= '0;
      spike_cnt <= '0;
    end else if (restart) begin
      len       <= (window_len == '0) ? LEN_ONE : window_len;
      step_cnt  <= '0;
      spike_cnt <= '0;
    end else if (state == RUN && stop) begin
      step_cnt  <= '0;
      spike_cnt <= '0;
    end else if (run_step) begin
      if (win_end) begin
        step_cnt  <= '0;
        spike_cnt <= '0;
      end else begin
        step_cnt  <= step_cnt + LEN_ONE;
        spike_cnt <= spike_cnt_next;
      end
    end
  end

`ifdef LIF_SPIKE_WINDOW_INDEX_EN
  // Window index advances on every window end, pushed or dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       win_idx <= '0;
    else if (restart) win_idx <= '0;
    else if (win_end) win_idx <= win_idx + 8'd1;
  end

  assign push_word = {win_idx, spike_cnt_next};
  assign out_index = head_word[ENTRY_W-1:COUNT_BITS];
`else
  assign push_word = spike_cnt_next;
`endif

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign out_valid  = !fifo_empty;
  assign pop        = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok    = win_end && (!fifo_full || pop);
  assign push_drop  = win_end && fifo_full && !pop;
  assign head_word  = mem[rd_ptr[AW-1:0]];
  assign out_data   = head_word[COUNT_BITS-1:0];

  // FIFO storage and pointers; storage is cleared so out_data reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_word;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Sticky drop flag, cleared only by start or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         dropped <= 1'b0;
    else if (restart)   dropped <= 1'b0;
    else if (push_drop) dropped <= 1'b1;
  end

endmodule

// File: tb/tb_lif_spike_window.sv
// tb_lif_spike_window: directed vector table plus hand-written sequences for
// saturation, FIFO-full drop/pop, stop/restart and asynchronous reset.
module tb_lif_spike_window;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, step_valid, spike_in, out_ready;
  logic [7:0] window_len;
  logic [7:0] out_data;
  logic       out_valid, dropped, busy;
  logic [3:0] out_data4;
  logic       out_valid4, dropped4, busy4;
`ifdef LIF_SPIKE_WINDOW_INDEX_EN
  logic [7:0] out_index, out_index4;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lif_spike_window #(.COUNT_BITS(8), .WINDOW_BITS(8), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .window_len(window_len),
    .step_valid(step_valid), .spike_in(spike_in), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .dropped(dropped), .busy(busy)
`ifdef LIF_SPIKE_WINDOW_INDEX_EN
    , .out_index(out_index)
`endif
  );

  lif_spike_window #(.COUNT_BITS(4), .WINDOW_BITS(8), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .window_len(window_len),
    .step_valid(step_valid), .spike_in(spike_in), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready), .dropped(dropped4), .busy(busy4)
`ifdef LIF_SPIKE_WINDOW_INDEX_EN
    , .out_index(out_index4)
`endif
  );

  typedef struct {
    logic       start, stop;
    logic [7:0] wlen;
    logic       sv, sp, rdy;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_busy, e_drop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic sp_, logic [7:0] wl, logic v, logic s,
                              logic ev, logic [7:0] ed, logic eb);
    vec_t r;
    r.start = st; r.stop = sp_; r.wlen = wl; r.sv = v; r.sp = s; r.rdy = 1'b1;
    r.e_valid = ev; r.e_data = ed; r.e_busy = eb; r.e_drop = 1'b0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; step_valid = 0; spike_in = 0;
  endtask

  task automatic step(input logic s);
    step_valid = 1; spike_in = s;
    tick();
    step_valid = 0; spike_in = 0;
  endtask

  task automatic do_start(input logic [7:0] wl);
    start = 1; window_len = wl;
    tick();
    start = 0;
  endtask

  initial begin
    rst_n = 0; out_ready = 1; window_len = 0;
    idle_inputs();
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_dropped", dropped, 0);
    chk("reset_data", out_data, 0);
    #21 rst_n = 1;
    tick();

    //            start stop wlen  sv sp   valid data busy
    tbl.push_back(mk(1, 0, 8'd4, 0, 0,   0, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0, 1, 1,   0, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0, 1, 1,   0, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0, 1, 0,   0, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0, 1, 1,   1, 3, 1));
    tbl.push_back(mk(0, 0, 8'd0, 1, 0,   0, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0, 0, 1,   0, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0, 1, 1,   0, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0, 1, 0,   0, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0, 1, 0,   1, 1, 1));
    tbl.push_back(mk(0, 0, 8'd0, 0, 0,   0, 0, 1));
    tbl.push_back(mk(1, 0, 8'd0, 0, 0,   0, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0, 1, 1,   1, 1, 1));
    tbl.push_back(mk(0, 0, 8'd0, 1, 1,   1, 1, 1));
    tbl.push_back(mk(0, 0, 8'd0, 1, 0,   1, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0, 0, 0,   0, 0, 1));
    tbl.push_back(mk(1, 1, 8'd5, 0, 0,   0, 0, 0));
    tbl.push_back(mk(0, 0, 8'd0, 1, 1,   0, 0, 0));
    tbl.push_back(mk(1, 0, 8'd3, 0, 0,   0, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0, 1, 1,   0, 0, 1));
    tbl.push_back(mk(1, 0, 8'd1, 0, 0,   0, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0, 1, 0,   1, 0, 1));
    tbl.push_back(mk(0, 1, 8'd0, 0, 0,   0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start; stop = tbl[i].stop; window_len = tbl[i].wlen;
      step_valid = tbl[i].sv; spike_in = tbl[i].sp; out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].e_valid);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_dropped", i), dropped, tbl[i].e_drop);
      if (tbl[i].e_valid) chk($sformatf("vec%0d_data", i), out_data, tbl[i].e_data);
    end
    idle_inputs();

    // Saturation: 255-step window, spike every step.
    out_ready = 0;
    do_start(8'd255);
    for (int i = 0; i < 254; i++) step(1);
    chk("sat_not_yet_valid", out_valid, 0);
    step(1);
    chk("sat8_valid", out_valid, 1);
    chk("sat8_data", out_data, 255);
    chk("sat4_valid", out_valid4, 1);
    chk("sat4_data", out_data4, 15);
    out_ready = 1;
    tick();
    chk("sat_drained", out_valid, 0);
    stop = 1; tick(); stop = 0;

    // FIFO full: five length-1 windows with no consumer, then push on pop.
    out_ready = 0;
    do_start(8'd1);
    step(1); step(0); step(0); step(1);
    chk("full4_dropped", dropped, 0);
    chk("full4_head", out_data, 1);
    step(0);
    chk("full5_dropped", dropped, 1);
    out_ready = 1;
    step(1);
    chk("pushpop_head", out_data, 0);
    chk("pushpop_dropped_sticky", dropped, 1);
    tick(); chk("drain1", out_data, 0);
    tick(); chk("drain2", out_data, 1);
    tick(); chk("drain3", out_data, 1);
    chk("drain3_valid", out_valid, 1);
    tick(); chk("drain_empty", out_valid, 0);

    // Mid-window stop, then fresh start: partial count must not appear.
    do_start(8'd2);
    chk("restart_clears_dropped", dropped, 0);
    step(1);
    stop = 1; tick(); stop = 0;
    chk("stop_busy", busy, 0);
    step(1);
    chk("idle_step_ignored", out_valid, 0);
    do_start(8'd2);
    step(0);
    step(1);
    chk("post_start_valid", out_valid, 1);
    chk("post_start_data", out_data, 1);
`ifdef LIF_SPIKE_WINDOW_INDEX_EN
    chk("post_start_index", out_index, 0);
`endif
    tick();
    chk("post_start_drained", out_valid, 0);

    // Asynchronous reset mid-RUN with two entries queued.
    out_ready = 0;
    do_start(8'd1);
    step(1); step(1);
    chk("prereset_valid", out_valid, 1);
    #3 rst_n = 0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_dropped", dropped, 0);
    chk("async_rst_data", out_data, 0);
    #3 rst_n = 1;
    tick();
    chk("after_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
